// File: rtl/uart_pkg.sv
// Shared encodings and defaults for the UART transmit scheduler.
package uart_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_SEND       = 2'd1;
    localparam logic [1:0] ST_WAIT_START = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE       = ST_IDLE,
        S_SEND       = ST_SEND,
        S_WAIT_START = ST_WAIT_START,
        S_WAIT_DONE  = ST_WAIT_DONE
    } sched_state_e;

    localparam int START_TIMEOUT_DEF = 4;
    localparam int TMO_W             = 4;

endpackage

// File: rtl/uart_tx_sched_arbiter.sv
// Combinational round-robin arbiter: search starts one past last_i and wraps.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);

    int          cand;
    logic [IW-1:0] cand_idx;
    logic        found;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_i) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IW'(cand);
            if (en_i && !found && req_i[cand_idx]) begin
                found           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NREQ byte streams.
// Define UART_TX_SCHED_LOCK_EN to hold the grant for a whole packet (REQ_LAST_I).
//
// state      | meaning
// IDLE       | wait for an eligible requester while the UART is free
// SEND       | one-cycle TX_VALID pulse to the UART
// WAIT_START | wait for busy to rise, bounded by START_TIMEOUT cycles
// WAIT_DONE  | wait for busy to fall
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic              CLK_I,
    input  logic              RESET_I,
    input  logic [NREQ-1:0]   REQ_VALID_I,
    input  logic [8*NREQ-1:0] REQ_DATA_I,
    input  logic [NREQ-1:0]   REQ_LAST_I,
    output logic [NREQ-1:0]   REQ_READY_O,
    output logic [NREQ-1:0]   GRANT_O,
    output logic [7:0]        UART_TX_DATA_O,
    output logic              UART_TX_VALID_O,
    input  logic              UART_TX_BUSY_I,
    output logic              IDLE_O
);

    localparam int IW = $clog2(NREQ);

    sched_state_e      state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q;
    logic              idle_q;
    logic              lock_q, lock_d;

    logic [NREQ-1:0]   arb_req;
    logic [NREQ-1:0]   arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              arb_en;
    logic              accept;
    logic              unused_last_ok;

    assign unused_last_ok = ^REQ_LAST_I;

`ifdef UART_TX_SCHED_LOCK_EN
    // A held lock narrows eligibility to the current owner.
    assign arb_req = lock_q ? (REQ_VALID_I & grant_q) : REQ_VALID_I;
`else
    assign arb_req = REQ_VALID_I;
    assign lock_q  = 1'b0;
    assign lock_d  = 1'b0;
`endif

    assign arb_en = (state_q == S_IDLE) && !UART_TX_BUSY_I;
    assign accept = |arb_gnt;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i  (arb_req),
        .last_i (last_q),
        .en_i   (arb_en),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        data_d  = data_q;
`ifdef UART_TX_SCHED_LOCK_EN
        lock_d  = lock_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d  = REQ_DATA_I[{arb_idx, 3'b000} +: 8];
                    grant_d = arb_gnt;
                    state_d = S_SEND;
`ifdef UART_TX_SCHED_LOCK_EN
                    lock_d = !REQ_LAST_I[arb_idx];
                    if (REQ_LAST_I[arb_idx]) begin
                        last_d = arb_idx;
                    end
`else
                    last_d = arb_idx;
`endif
                end
            end
            S_SEND: begin
                cnt_d   = TMO_W'(START_TIMEOUT);
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                // Busy wins over an expiring counter in the same cycle.
                if (UART_TX_BUSY_I) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - TMO_W'(1);
                    end
                    if (cnt_q <= TMO_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!UART_TX_BUSY_I) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if ((state_q != S_IDLE) && (state_d == S_IDLE) && !lock_q) begin
            grant_d = '0;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RESET_I) begin
            state_q <= S_IDLE;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            valid_q <= (state_d == S_SEND);
            idle_q  <= (state_d == S_IDLE) && !lock_d;
        end
    end

`ifdef UART_TX_SCHED_LOCK_EN
    always_ff @(posedge CLK_I) begin
        if (RESET_I) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    assign REQ_READY_O     = arb_gnt;
    assign GRANT_O         = grant_q;
    assign UART_TX_DATA_O  = data_q;
    assign UART_TX_VALID_O = valid_q;
    assign IDLE_O          = idle_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: per-requester byte queues, a UART busy model,
// and a round-robin reference computed from queue occupancy.
module tb_uart_tx_sched;

    localparam int NREQ = 4;
    localparam int TMO  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              busy_i;
    logic              idle;

    uart_tx_sched #(.NREQ(NREQ), .START_TIMEOUT(TMO)) dut (
        .CLK_I           (clk),
        .RESET_I         (rst),
        .REQ_VALID_I     (req_valid),
        .REQ_DATA_I      (req_data),
        .REQ_LAST_I      (req_last),
        .REQ_READY_O     (req_ready),
        .GRANT_O         (grant),
        .UART_TX_DATA_O  (tx_data),
        .UART_TX_VALID_O (tx_valid),
        .UART_TX_BUSY_I  (busy_i),
        .IDLE_O          (idle)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; logic [7:0] data; } exp_t;

    logic [7:0] rq[NREQ][$];
    bit         rl[NREQ][$];
    exp_t       exp_q[$];
    int         nb[NREQ];
    int         fix_data = -1;
    bit         pkt_mode = 1'b0;
    int         m_last   = NREQ - 1;

    int checks = 0;
    int errors = 0;

    bit u_busy = 1'b0, force_busy = 1'b0, u_noresp = 1'b0;
    int u_len = 3, u_dly = 0, u_left = 0, u_wait = 0;
    logic [NREQ-1:0] rdy_seen = '0, prev_rdy = '0;
    bit vld_seen = 1'b0;

    assign busy_i = u_busy | force_busy;

    function automatic void chk(bit ok, string name, int act, int expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic void drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = (rq[i].size() > 0);
            req_data[8*i +: 8]  = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
            req_last[i]         = (rl[i].size() > 0) ? rl[i][0] : 1'b1;
        end
    endfunction

    // Reference: among requesters with bytes left, the first after the last winner wins;
    // with packet locking, the owner keeps winning until it sends a last-flagged byte.
    task automatic load_batch();
        int pos[NREQ];
        int total, w, c, lk_id;
        bit lk;
        logic [7:0] d;
        total = 0;
        lk = 1'b0;
        lk_id = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos[i] = 0;
            for (int j = 0; j < nb[i]; j++) begin
                d = (fix_data >= 0) ? 8'(fix_data) : 8'($urandom);
                rq[i].push_back(d);
                rl[i].push_back(pkt_mode ? (j == nb[i] - 1) : 1'b1);
            end
            total += nb[i];
        end
        for (int t = 0; t < total; t++) begin
            w = -1;
            if (lk) w = lk_id;
            else begin
                for (int k = 1; k <= NREQ; k++) begin
                    c = (m_last + k) % NREQ;
                    if (w < 0 && pos[c] < nb[c]) w = c;
                end
            end
            exp_q.push_back('{w, rq[w][pos[w]]});
`ifdef UART_TX_SCHED_LOCK_EN
            lk = !rl[w][pos[w]];
            lk_id = w;
            if (!lk) m_last = w;
`else
            m_last = w;
`endif
            pos[w]++;
        end
        drive_inputs();
    endtask

    // Monitor: pops the scoreboard on every UART send pulse.
    always @(negedge clk) begin
        exp_t e;
        rdy_seen = '0;
        vld_seen = 1'b0;
        if (rst) begin
            prev_rdy = '0;
        end else begin
            rdy_seen = req_ready;
            vld_seen = tx_valid;
            if (req_ready != '0)
                chk($onehot(req_ready), "ready_onehot", int'(req_ready), 0);
            if (tx_valid || prev_rdy != '0)
                chk(tx_valid == (prev_rdy != '0), "accept_to_valid", int'(tx_valid), int'(prev_rdy != '0));
            if (tx_valid) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "sb_unexpected_send", int'(tx_data), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(tx_data == e.data, "sb_data", int'(tx_data), int'(e.data));
                    chk(grant == (NREQ'(1) << e.idx), "sb_grant", int'(grant), int'(NREQ'(1) << e.idx));
                end
            end
            prev_rdy = req_ready;
        end
    end

    // Requester handshake and UART busy model.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (rdy_seen[i] && rq[i].size() > 0) begin
                void'(rq[i].pop_front());
                void'(rl[i].pop_front());
            end
        end
        if (u_busy) begin
            if (u_left <= 1) u_busy = 1'b0;
            else u_left--;
        end else if (u_wait > 0) begin
            u_wait--;
            if (u_wait == 0) begin
                u_busy = 1'b1;
                u_left = u_len;
            end
        end
        if (vld_seen && !u_noresp) begin
            if (u_dly == 0) begin
                u_busy = 1'b1;
                u_left = u_len;
            end else begin
                u_wait = u_dly;
            end
        end
        drive_inputs();
    end

    function automatic bit queues_empty();
        for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) return 1'b0;
        return exp_q.size() == 0;
    endfunction

    task automatic wait_drain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(queues_empty() && idle && !busy_i) && n < 3000);
        chk(n < 3000, "drain_timeout", n, 3000);
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    int n;

    initial begin
        rst = 1'b1;
        drive_inputs();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk(req_ready == '0, "rst_ready", int'(req_ready), 0);
        chk(grant == '0, "rst_grant", int'(grant), 0);
        chk(tx_valid == 1'b0, "rst_valid", int'(tx_valid), 0);
        chk(tx_data == 8'h00, "rst_data", int'(tx_data), 0);
        chk(idle == 1'b1, "rst_idle", int'(idle), 1);

        // Single requester, 10-cycle busy.
        u_len = 10; u_dly = 0;
        nb = '{1, 0, 0, 0};
        fix_data = 8'h41;
        sync();
        load_batch();
        fix_data = -1;
        @(negedge clk);
        chk(req_ready == 4'b0001, "single_ready", int'(req_ready), 1);
        @(negedge clk);
        chk(req_ready == '0, "single_ready_once", int'(req_ready), 0);
        chk(tx_valid && tx_data == 8'h41, "single_send", int'(tx_data), 8'h41);
        n = 0;
        do begin @(negedge clk); n++; end while (!idle && n < 40);
        chk(n == 12, "single_idle_cycles", n, 12);
        chk(!busy_i, "single_idle_after_busy", int'(busy_i), 0);
        wait_drain();

        // Fairness: all requesters valid together.
        u_len = 2;
        nb = '{2, 2, 2, 2};
        sync();
        load_batch();
        wait_drain();

        // Busy gate.
        sync();
        force_busy = 1'b1;
        nb = '{0, 1, 0, 0};
        load_batch();
        repeat (5) begin
            @(negedge clk);
            chk(req_ready == '0, "busy_gate_hold", int'(req_ready), 0);
        end
        sync();
        force_busy = 1'b0;
        @(negedge clk);
        chk(req_ready == 4'b0010, "busy_gate_release", int'(req_ready), 2);
        wait_drain();

        // Start timeout: UART never shows busy.
        u_noresp = 1'b1;
        nb = '{0, 0, 0, 2};
        sync();
        load_batch();
        n = 0;
        do begin @(negedge clk); n++; end while (!tx_valid && n < 20);
        chk(tx_valid, "timeout_first_send", int'(tx_valid), 1);
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == '0 && n < 20);
        chk(n == TMO + 1, "timeout_reaccept", n, TMO + 1);
        chk(idle, "timeout_idle", int'(idle), 1);
        wait_drain();
        u_noresp = 1'b0;

        // Packet traffic: req2 three bytes (last on third) against req0.
        nb = '{0, 1, 0, 0};
        sync();
        load_batch();
        wait_drain();
        pkt_mode = 1'b1;
        nb = '{2, 0, 3, 0};
        sync();
        load_batch();
        wait_drain();
        pkt_mode = 1'b0;

        // Reset while in WAIT_DONE.
        u_len = 20;
        nb = '{0, 0, 1, 0};
        sync();
        load_batch();
        n = 0;
        do begin @(negedge clk); n++; end while (!tx_valid && n < 20);
        chk(tx_valid, "rstmid_send", int'(tx_valid), 1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        m_last = NREQ - 1;
        @(negedge clk);
        chk(grant == '0, "rstmid_grant", int'(grant), 0);
        chk(!tx_valid, "rstmid_valid", int'(tx_valid), 0);
        chk(tx_data == 8'h00, "rstmid_data", int'(tx_data), 0);
        chk(idle, "rstmid_idle", int'(idle), 1);
        u_len = 3;
        nb = '{1, 1, 0, 0};
        sync();
        load_batch();
        wait_drain();

        // Randomised batches.
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < NREQ; i++) nb[i] = $urandom_range(0, 3);
            u_len    = $urandom_range(1, 6);
            u_dly    = $urandom_range(0, 3);
            u_noresp = ($urandom_range(0, 4) == 0);
            sync();
            load_batch();
            wait_drain();
        end

        chk(exp_q.size() == 0, "sb_leftover", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
